// File: rtl/rv_arb_pkg.sv
// rv_arb_pkg: arbiter state type and the round-robin search shared by rv_arb_mux.
package rv_arb_pkg;
  localparam int MAX_CH = 16;
  localparam int MAX_CH_W = 4;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  // {found, index} of the first set bit in valid after ptr, wrapping at num_ch
  function automatic logic [MAX_CH_W:0] rr_next(input logic [MAX_CH-1:0] valid, input logic [MAX_CH_W-1:0] ptr, input int num_ch);
    logic [MAX_CH_W:0] res;
    logic [MAX_CH_W-1:0] c;
    res = '0;
    for (int i = MAX_CH; i >= 1; i--) begin
      if (i <= num_ch) begin
        c = MAX_CH_W'((int'(ptr) + i) % num_ch);
        if (valid[c]) res = {1'b1, c};
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/rv_arb_mux_if.sv
// rv_arb_mux_if: multi-sender input side and single receiver output side of rv_arb_mux.
interface rv_arb_mux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0] in_last;
  logic [NUM_CH-1:0] in_ready;
  logic out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_last;
  logic [CH_W-1:0] out_ch;
  logic out_ready;
  modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data, out_last, out_ch);
  modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data, out_last, out_ch);
endinterface

// File: rtl/rv_skid_buffer.sv
// rv_skid_buffer: two-entry ready/valid buffer; in_ready comes from a flop so out_ready never
// reaches the upstream side combinationally.
module rv_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic take, main_free;
  always_comb begin
    take = in_valid && !skid_v_q;
    main_free = !main_v_q || out_ready;
    main_v_d = main_free ? (skid_v_q || take) : main_v_q;
    main_d = !main_free ? main_q : skid_v_q ? skid_q : take ? in_data : main_q;
    skid_v_d = !main_free && (skid_v_q || take);
    skid_d = (take && !main_free) ? in_data : skid_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  assign in_ready = reset_n && !skid_v_q;
  assign out_valid = main_v_q;
  assign out_data = main_q;
endmodule

// File: rtl/rv_arb_mux.sv
// rv_arb_mux: round-robin NUM_CH-to-1 ready/valid arbiter-multiplexer with optional
// whole-packet grant lock and a skid-buffered registered output.
module rv_arb_mux
  import rv_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH = 4,
  parameter int LOCK_ON_LAST = 1
) (
  input logic clk,
  input logic reset_n,
  rv_arb_mux_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic last;
    logic [CH_W-1:0] ch;
  } beat_t;
  arb_state_e state_q, state_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d, lock_ch_q, lock_ch_d, grant;
  logic grant_valid, skid_ready, accept;
  logic [MAX_CH-1:0] valid_ext;
  logic [MAX_CH_W:0] rr;
  logic rr_unused;
  beat_t in_beat, out_beat;
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_CH-1:0] = bus.in_valid;
    rr = rr_next(valid_ext, MAX_CH_W'(rr_ptr_q), NUM_CH);
    grant = state_q == LOCKED ? lock_ch_q : rr[CH_W-1:0];
    grant_valid = state_q == LOCKED ? bus.in_valid[lock_ch_q] : rr[MAX_CH_W];
    accept = grant_valid && skid_ready;
    bus.in_ready = '0;
    bus.in_ready[grant] = accept;
    in_beat = '{data: bus.in_data[grant], last: bus.in_last[grant], ch: grant};
    rr_ptr_d = accept ? grant : rr_ptr_q;
    lock_ch_d = accept ? grant : lock_ch_q;
    state_d = !accept ? state_q : (LOCK_ON_LAST != 0 && !bus.in_last[grant]) ? LOCKED : IDLE;
  end
  assign rr_unused = ^rr;
  // rr_ptr starts at the last channel so channel 0 is searched first
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      rr_ptr_q <= CH_W'(NUM_CH - 1);
      lock_ch_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_ch_q <= lock_ch_d;
    end
  rv_skid_buffer #(.W($bits(beat_t))) u_skid (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(grant_valid),
    .in_data(in_beat),
    .in_ready(skid_ready),
    .out_valid(bus.out_valid),
    .out_data(out_beat),
    .out_ready(bus.out_ready)
  );
  assign bus.out_data = out_beat.data;
  assign bus.out_last = out_beat.last;
  assign bus.out_ch = out_beat.ch;
endmodule

// File: tb/tb_rv_arb_mux.sv
// tb_rv_arb_mux: randomized scoreboard bench driving a packet-lock and a per-beat rv_arb_mux
// from the same stimulus and checking both against an arbitration-rule model.
module tb_rv_arb_mux;
  localparam int DW = 8;
  localparam int N = 4;
  typedef struct packed {
    logic [DW-1:0] data;
    logic last;
    logic [1:0] ch;
  } beat_t;
  logic clk = 0;
  logic reset_n = 1;
  logic out_rdy = 1;
  logic [DW:0] stim [N][$];
  bit rpat [$];
  int vprob = 100;
  int rprob = 100;
  bit flush = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string what, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%s expected=%s", what, got, want);
    end
  endtask

  task automatic push(input int c, input bit last, input logic [DW-1:0] d);
    stim[c].push_back({last, d});
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rpat.size() > 0) out_rdy = rpat.pop_front();
    else out_rdy = $urandom_range(99) < rprob;
  end

  for (genvar m = 0; m < 2; m++) begin : g
    rv_arb_mux_if #(.DATA_WIDTH(DW), .NUM_CH(N)) bus ();
    rv_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(N), .LOCK_ON_LAST(m)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
    assign bus.out_ready = out_rdy;
    beat_t sb [$];
    beat_t pend, got;
    bit pend_v = 0, pop_v = 0, idle = 1;
    int idx [N];
    int gi, pend_g;
    int ptr = N - 1, lock = -1;
    logic [N-1:0] took = '0, exp_rdy;
    logic [N-1:0] one = 1;

    // senders: hold each beat until accepted, random gaps between beats
    initial begin
      for (int c = 0; c < N; c++) idx[c] = 0;
      bus.in_valid = '0;
      bus.in_data = '0;
      bus.in_last = '0;
      forever begin
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
          if (flush) idx[c] = stim[c].size();
          else if (took[c]) idx[c]++;
          if (flush || took[c] || !bus.in_valid[c]) begin
            if (idx[c] < stim[c].size() && $urandom_range(99) < vprob) begin
              bus.in_valid[c] = 1'b1;
              {bus.in_last[c], bus.in_data[c]} = stim[c][idx[c]];
            end else bus.in_valid[c] = 1'b0;
          end
        end
        idle = bus.in_valid == '0;
        for (int c = 0; c < N; c++) if (idx[c] < stim[c].size()) idle = 0;
      end
    end

    // input monitor: decide the rule-based grant and expected ready, queue the expected beat
    initial forever begin
      @(negedge clk);
      if (!reset_n) begin
        took = '0;
        pend_v = 0;
        chk(bus.in_ready == '0 && !bus.out_valid, $sformatf("L%0d reset_idle", m),
            $sformatf("rdy=%b ov=%b", bus.in_ready, bus.out_valid), "rdy=0000 ov=0");
      end else begin
        gi = -1;
        if (lock >= 0) gi = bus.in_valid[lock] ? lock : -1;
        else for (int i = 1; i <= N; i++) if (gi < 0 && bus.in_valid[(ptr + i) % N]) gi = (ptr + i) % N;
        exp_rdy = (gi >= 0 && sb.size() < 2) ? one << gi : '0;
        chk(bus.in_ready == exp_rdy, $sformatf("L%0d in_ready", m), $sformatf("%b", bus.in_ready), $sformatf("%b", exp_rdy));
        took = bus.in_valid & bus.in_ready;
        pend_v = exp_rdy != '0;
        pend_g = gi;
        if (pend_v) pend = '{data: bus.in_data[gi], last: bus.in_last[gi], ch: 2'(gi)};
      end
    end

    // output monitor: compare presented beats with the scoreboard head
    initial forever begin
      @(negedge clk);
      pop_v = 0;
      if (reset_n) begin
        chk(bus.out_valid == (sb.size() > 0), $sformatf("L%0d out_valid", m), $sformatf("%b", bus.out_valid), $sformatf("%b", sb.size() > 0));
        if (bus.out_valid && sb.size() > 0) begin
          got = '{data: bus.out_data, last: bus.out_last, ch: bus.out_ch};
          chk(got == sb[0], $sformatf("L%0d out_beat", m),
              $sformatf("ch%0d d%h l%b", got.ch, got.data, got.last), $sformatf("ch%0d d%h l%b", sb[0].ch, sb[0].data, sb[0].last));
          pop_v = bus.out_ready;
        end
      end
    end

    // model state advances on the clock edge the transfers happen
    initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        sb.delete();
        ptr = N - 1;
        lock = -1;
      end else begin
        if (pop_v) void'(sb.pop_front());
        if (pend_v) begin
          sb.push_back(pend);
          ptr = pend_g;
          lock = (m == 1 && !pend.last) ? pend_g : -1;
        end
      end
    end
  end

  task automatic wait_idle(input int limit, output int n);
    n = 2;
    repeat (2) @(posedge clk);
    while (!(g[0].idle && g[1].idle && g[0].sb.size() == 0 && g[1].sb.size() == 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(n < limit, "drain", $sformatf("%0d cycles", n), $sformatf("<%0d cycles", limit));
  endtask

  initial begin
    int n;
    int len;
    #1 reset_n = 0;
    for (int k = 0; k < 3; k++) for (int c = 0; c < N; c++) push(c, 1'b1, 8'(c * 16 + k));
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    wait_idle(200, n);
    for (int k = 0; k < 3; k++) push(1, k == 2, 8'h40 + 8'(k));
    push(0, 1'b1, 8'h50);
    push(2, 1'b1, 8'h52);
    wait_idle(200, n);
    for (int k = 0; k < 8; k++) push(3, 1'b1, 8'h60 + 8'(k));
    repeat (3) @(posedge clk);
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    wait_idle(200, n);
    @(negedge clk);
    for (int k = 0; k < 10; k++) push(2, k % 3 == 2, 8'h70 + 8'(k));
    wait_idle(200, n);
    chk(n <= 16, "ch2_rate", $sformatf("%0d cycles", n), "<=16 cycles");
    vprob = 70;
    rprob = 60;
    for (int c = 0; c < N; c++) for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) push(c, k == len - 1, 8'($urandom));
    end
    wait_idle(3000, n);
    vprob = 100;
    rprob = 0;
    for (int k = 0; k < 6; k++) push(1, k == 5, 8'h80 + 8'(k));
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk(g[0].bus.out_valid && g[0].bus.in_ready == '0, "L0 stall_full", $sformatf("ov=%b rdy=%b", g[0].bus.out_valid, g[0].bus.in_ready), "ov=1 rdy=0000");
    chk(g[1].bus.out_valid && g[1].bus.in_ready == '0, "L1 stall_full", $sformatf("ov=%b rdy=%b", g[1].bus.out_valid, g[1].bus.in_ready), "ov=1 rdy=0000");
    @(posedge clk);
    #2 reset_n = 0;
    flush = 1;
    #1;
    chk(!g[0].bus.out_valid && !g[1].bus.out_valid, "async_reset", $sformatf("ov=%b%b", g[0].bus.out_valid, g[1].bus.out_valid), "ov=00");
    @(posedge clk);
    #2 flush = 0;
    for (int c = N - 1; c >= 0; c--) push(c, 1'b1, 8'h90 + 8'(c));
    rprob = 100;
    @(posedge clk);
    #2 reset_n = 1;
    n = 0;
    while (!g[1].bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(g[1].bus.out_valid && g[1].bus.out_ch == 2'd0, "first_after_reset", $sformatf("ov=%b ch%0d", g[1].bus.out_valid, g[1].bus.out_ch), "ov=1 ch0");
    wait_idle(200, n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
